// File: rtl/riffa_pkg.sv
// Shared constants and state encoding for the RIFFA TX channel arbiter.
// Width defaults match the 64-bit RIFFA channel used by the command pipeline.
package riffa_pkg;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_LEN_W      = 32;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_BEAT = DEF_DATA_W / WORD_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        REQ  = 3'd2,
        XFER = 3'd3,
        DONE = 3'd4
    } state_t;

    // RIFFA lengths count 32-bit words; one data beat carries this many.
    function automatic int words_per_beat(input int data_w);
        return data_w / WORD_W;
    endfunction

endpackage

// File: rtl/riffa_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// index ptr (wrapping modulo NUM_REQ) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W:0] pos_s;

    // Walk the rotated priority order; the double loop keeps every request index constant.
    always_comb begin
        grant = {NUM_REQ{1'b0}};
        idx   = {IDX_W{1'b0}};
        found = 1'b0;
        pos_s = {(IDX_W+1){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos_s >= (IDX_W+1)'(NUM_REQ)) begin
                pos_s = pos_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                pos_s = pos_s;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (pos_s[IDX_W-1:0] == IDX_W'(i))) begin
                    found    = 1'b1;
                    idx      = IDX_W'(i);
                    grant[i] = 1'b1;
                end else begin
                    found = found;
                end
            end
        end
    end

endmodule

// File: rtl/riffa_tx_arbiter.sv
// Shares one RIFFA TX channel among NUM_REQ requesters: round-robin grant,
// CHNL_TX/ACK handshake, data mux and word counting to close each transaction.
import riffa_pkg::*;

module riffa_tx_arbiter #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_grant,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_data_valid,
    output logic [NUM_REQ-1:0]        req_data_ren,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      CHNL_TX,
    input  logic                      CHNL_TX_ACK,
    output logic                      CHNL_TX_LAST,
    output logic [LEN_W-1:0]          CHNL_TX_LEN,
    output logic [30:0]               CHNL_TX_OFF,
    output logic [DATA_W-1:0]         CHNL_TX_DATA,
    output logic                      CHNL_TX_DATA_VALID,
    input  logic                      CHNL_TX_DATA_REN,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WPB   = words_per_beat(DATA_W);
    localparam logic [LEN_W:0] WPB_INC = (LEN_W+1)'(WPB);

    state_t               state_r, next_state_s;
    logic [IDX_W-1:0]     ptr_r, start_s, owner_r, arb_idx_s;
    logic                 ptr_valid_r, arb_found_s;
    logic [NUM_REQ-1:0]   arb_grant_s, grant_r, done_r;
    logic [LEN_W-1:0]     len_r, sel_len_s;
    logic                 last_r, sel_last_s;
    logic [LEN_W:0]       cnt_r, cnt_inc_s;
    logic                 tx_r, busy_r;
    logic [DATA_W-1:0]    own_data_s;
    logic                 own_dv_s, xfer_s, beat_s;

    // Priority starts one past the last owner; before any completion index 0 leads.
    always_comb begin
        if (!ptr_valid_r) begin
            start_s = {IDX_W{1'b0}};
        end else if (ptr_r == IDX_W'(NUM_REQ-1)) begin
            start_s = {IDX_W{1'b0}};
        end else begin
            start_s = ptr_r + IDX_W'(1);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (start_s),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .found (arb_found_s)
    );

    // Select the arbitration winner's length/last and the owner's data path.
    always_comb begin
        sel_len_s  = {LEN_W{1'b0}};
        sel_last_s = 1'b0;
        own_data_s = {DATA_W{1'b0}};
        own_dv_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx_s == IDX_W'(i)) begin
                sel_len_s  = req_len[i*LEN_W +: LEN_W];
                sel_last_s = req_last[i];
            end else begin
                sel_last_s = sel_last_s;
            end
            if (owner_r == IDX_W'(i)) begin
                own_data_s = req_data[i*DATA_W +: DATA_W];
                own_dv_s   = req_data_valid[i];
            end else begin
                own_dv_s = own_dv_s;
            end
        end
    end

    assign xfer_s    = (state_r == XFER);
    assign beat_s    = xfer_s & own_dv_s & CHNL_TX_DATA_REN;
    assign cnt_inc_s = cnt_r + WPB_INC;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; an odd length finishes on a padded final beat.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req_valid) next_state_s = ARB;
                else            next_state_s = IDLE;
            end
            ARB: begin
                if (arb_found_s) next_state_s = REQ;
                else             next_state_s = IDLE;
            end
            REQ: begin
                if (!CHNL_TX_ACK)                    next_state_s = REQ;
                else if (len_r == {LEN_W{1'b0}})     next_state_s = DONE;
                else                                 next_state_s = XFER;
            end
            XFER: begin
                if (beat_s && (cnt_inc_s >= {1'b0, len_r})) next_state_s = DONE;
                else                                         next_state_s = XFER;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Ownership, pointer, word counter and the registered channel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= {IDX_W{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            last_r      <= 1'b0;
            grant_r     <= {NUM_REQ{1'b0}};
            ptr_r       <= {IDX_W{1'b0}};
            ptr_valid_r <= 1'b0;
            cnt_r       <= {(LEN_W+1){1'b0}};
            tx_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= {NUM_REQ{1'b0}};
        end else begin
            case (state_r)
                ARB: begin
                    if (arb_found_s) begin
                        owner_r <= arb_idx_s;
                        len_r   <= sel_len_s;
                        last_r  <= sel_last_s;
                        grant_r <= arb_grant_s;
                    end
                end
                XFER: begin
                    if (beat_s) cnt_r <= cnt_inc_s;
                end
                DONE: begin
                    grant_r     <= {NUM_REQ{1'b0}};
                    ptr_r       <= owner_r;
                    ptr_valid_r <= 1'b1;
                    cnt_r       <= {(LEN_W+1){1'b0}};
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
            tx_r   <= (next_state_s == REQ) || (next_state_s == XFER);
            busy_r <= (next_state_s != IDLE);
            done_r <= (next_state_s == DONE) ? grant_r : {NUM_REQ{1'b0}};
        end
    end

    // Data-path outputs are only live for the owner while in XFER.
    always_comb begin
        if (xfer_s) begin
            CHNL_TX_DATA       = own_data_s;
            CHNL_TX_DATA_VALID = own_dv_s;
            req_data_ren       = grant_r & {NUM_REQ{CHNL_TX_DATA_REN}};
        end else begin
            CHNL_TX_DATA       = {DATA_W{1'b0}};
            CHNL_TX_DATA_VALID = 1'b0;
            req_data_ren       = {NUM_REQ{1'b0}};
        end
    end

    assign req_grant    = grant_r;
    assign req_done     = done_r;
    assign CHNL_TX      = tx_r;
    assign CHNL_TX_LAST = last_r;
    assign CHNL_TX_LEN  = len_r;
    assign CHNL_TX_OFF  = 31'd0;
    assign busy         = busy_r;

endmodule

// File: tb/tb_riffa_tx_arbiter.sv
// Directed self-checking bench for riffa_tx_arbiter (3 requesters, 64-bit data).
module tb_riffa_tx_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int LW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_grant;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_data_valid;
    logic [N-1:0]    req_data_ren;
    logic [N-1:0]    req_done;
    logic            CHNL_TX;
    logic            CHNL_TX_ACK;
    logic            CHNL_TX_LAST;
    logic [LW-1:0]   CHNL_TX_LEN;
    logic [30:0]     CHNL_TX_OFF;
    logic [DW-1:0]   CHNL_TX_DATA;
    logic            CHNL_TX_DATA_VALID;
    logic            CHNL_TX_DATA_REN;
    logic            busy;

    int checks = 0;
    int failures = 0;

    // Monitor state, written only by the negedge monitor.
    int beats = 0;
    int ren1_cnt = 0;
    int done_total = 0;
    int low_run = 0;
    int gap_at_rise = 0;
    logic prev_tx = 1'b0;

    riffa_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_len            (req_len),
        .req_last           (req_last),
        .req_grant          (req_grant),
        .req_data           (req_data),
        .req_data_valid     (req_data_valid),
        .req_data_ren       (req_data_ren),
        .req_done           (req_done),
        .CHNL_TX            (CHNL_TX),
        .CHNL_TX_ACK        (CHNL_TX_ACK),
        .CHNL_TX_LAST       (CHNL_TX_LAST),
        .CHNL_TX_LEN        (CHNL_TX_LEN),
        .CHNL_TX_OFF        (CHNL_TX_OFF),
        .CHNL_TX_DATA       (CHNL_TX_DATA),
        .CHNL_TX_DATA_VALID (CHNL_TX_DATA_VALID),
        .CHNL_TX_DATA_REN   (CHNL_TX_DATA_REN),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Count accepted beats, owner read enables, done pulses and idle gaps of CHNL_TX.
    always @(negedge clk) begin
        beats      <= beats + int'(CHNL_TX_DATA_VALID & CHNL_TX_DATA_REN);
        ren1_cnt   <= ren1_cnt + int'(req_data_ren[1]);
        done_total <= done_total + int'(req_done != 3'b000);
        if (CHNL_TX && !prev_tx) gap_at_rise <= low_run;
        low_run    <= CHNL_TX ? 0 : low_run + 1;
        prev_tx    <= CHNL_TX;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ACK whenever CHNL_TX is seen; drop req_valid bits not in keep once granted.
    task automatic run_txn(input int budget, input logic [N-1:0] keep, output logic [N-1:0] done_vec);
        done_vec = 3'b000;
        for (int k = 0; k < budget; k++) begin
            CHNL_TX_ACK = CHNL_TX;
            if (req_grant != 3'b000) req_valid = req_valid & keep;
            tick();
            if (req_done != 3'b000) begin
                done_vec = req_done;
                break;
            end
        end
        CHNL_TX_ACK = 1'b0;
        check("txn_completed", 64'(done_vec != 3'b000), 64'd1);
    endtask

    logic [N-1:0] dv;
    int b0, d0;

    initial begin
        rst_n            = 1'b0;
        req_valid        = 3'b000;
        req_len          = {N*LW{1'b0}};
        req_last         = 3'b000;
        req_data         = {64'hCCCC_0003_CCCC_0003, 64'hBBBB_0002_BBBB_0002, 64'hAAAA_0001_AAAA_0001};
        req_data_valid   = 3'b111;
        CHNL_TX_ACK      = 1'b0;
        CHNL_TX_DATA_REN = 1'b1;
        tick();
        tick();
        check("rst_tx", 64'(CHNL_TX), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(req_grant), 64'd0);
        check("rst_len", 64'(CHNL_TX_LEN), 64'd0);
        check("rst_data", CHNL_TX_DATA, 64'd0);
        check("rst_ren", 64'(req_data_ren), 64'd0);
        check("rst_off", 64'(CHNL_TX_OFF), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single requester 1, len=4: two 64-bit beats.
        b0 = beats;
        req_valid = 3'b010;
        req_len[LW +: LW] = 32'd4;
        req_last = 3'b010;
        tick();
        check("t1_arb_busy", 64'(busy), 64'd1);
        check("t1_arb_tx", 64'(CHNL_TX), 64'd0);
        tick();
        check("t1_req_tx", 64'(CHNL_TX), 64'd1);
        check("t1_grant", 64'(req_grant), 64'b010);
        check("t1_len", 64'(CHNL_TX_LEN), 64'd4);
        check("t1_last", 64'(CHNL_TX_LAST), 64'd1);
        check("t1_req_dv", 64'(CHNL_TX_DATA_VALID), 64'd0);
        req_valid = 3'b000;
        CHNL_TX_ACK = 1'b1;
        tick();
        CHNL_TX_ACK = 1'b0;
        check("t1_xfer_dv", 64'(CHNL_TX_DATA_VALID), 64'd1);
        check("t1_xfer_ren", 64'(req_data_ren), 64'b010);
        check("t1_xfer_data", CHNL_TX_DATA, 64'hBBBB_0002_BBBB_0002);
        tick();
        check("t1_beat2_tx", 64'(CHNL_TX), 64'd1);
        tick();
        check("t1_done_tx", 64'(CHNL_TX), 64'd0);
        check("t1_done_pulse", 64'(req_done), 64'b010);
        tick();
        check("t1_idle_done", 64'(req_done), 64'd0);
        check("t1_idle_grant", 64'(req_grant), 64'd0);
        check("t1_idle_busy", 64'(busy), 64'd0);
        check("t1_beats", 64'(beats - b0), 64'd2);

        // Odd length 3 on requester 2: two beats, last one padded.
        b0 = beats;
        req_valid = 3'b100;
        req_len[2*LW +: LW] = 32'd3;
        req_last = 3'b000;
        run_txn(40, 3'b000, dv);
        check("t3_done_vec", 64'(dv), 64'b100);
        check("t3_len", 64'(CHNL_TX_LEN), 64'd3);
        check("t3_beats", 64'(beats - b0), 64'd2);
        tick();

        // len=0 on requester 0: CHNL_TX waits for ACK, no beats, done right after ACK.
        b0 = beats;
        req_valid = 3'b001;
        req_len[0 +: LW] = 32'd0;
        tick();
        tick();
        check("t4_tx", 64'(CHNL_TX), 64'd1);
        check("t4_grant", 64'(req_grant), 64'b001);
        req_valid = 3'b000;
        tick();
        tick();
        check("t4_tx_wait", 64'(CHNL_TX), 64'd1);
        CHNL_TX_ACK = 1'b1;
        tick();
        CHNL_TX_ACK = 1'b0;
        check("t4_done", 64'(req_done), 64'b001);
        check("t4_tx_low", 64'(CHNL_TX), 64'd0);
        tick();
        check("t4_beats", 64'(beats - b0), 64'd0);

        // REN toggling, len=8 on requester 1: four beats, only the owner sees ren.
        b0 = beats;
        d0 = ren1_cnt;
        dv = 3'b000;
        req_valid = 3'b010;
        req_len[LW +: LW] = 32'd8;
        CHNL_TX_DATA_REN = 1'b0;
        for (int k = 0; k < 60; k++) begin
            CHNL_TX_ACK = CHNL_TX;
            CHNL_TX_DATA_REN = ~CHNL_TX_DATA_REN;
            if (req_grant[1]) req_valid = 3'b000;
            tick();
            check("t5_ren_nonowner", 64'(req_data_ren & 3'b101), 64'd0);
            if (req_done != 3'b000) begin
                dv = req_done;
                break;
            end
        end
        CHNL_TX_ACK = 1'b0;
        CHNL_TX_DATA_REN = 1'b1;
        check("t5_done_vec", 64'(dv), 64'b010);
        check("t5_beats", 64'(beats - b0), 64'd4);
        check("t5_owner_ren", 64'(ren1_cnt - d0), 64'd4);
        tick();

        // Reset mid-XFER on requester 2: everything clears asynchronously, no done pulse.
        d0 = done_total;
        req_valid = 3'b100;
        req_len[2*LW +: LW] = 32'd8;
        tick();
        tick();
        CHNL_TX_ACK = 1'b1;
        tick();
        CHNL_TX_ACK = 1'b0;
        check("t6_in_xfer", 64'(CHNL_TX_DATA_VALID), 64'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx", 64'(CHNL_TX), 64'd0);
        check("t6_rst_grant", 64'(req_grant), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_dv", 64'(CHNL_TX_DATA_VALID), 64'd0);
        check("t6_rst_data", CHNL_TX_DATA, 64'd0);
        check("t6_rst_ren", 64'(req_data_ren), 64'd0);
        req_valid = 3'b000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_no_done", 64'(done_total - d0), 64'd0);

        // All three at once after reset, len=2 each, held: order 0,1,2 then 0.
        req_len = {32'd2, 32'd2, 32'd2};
        req_valid = 3'b111;
        run_txn(40, 3'b111, dv);
        check("t7_first", 64'(dv), 64'b001);
        run_txn(40, 3'b111, dv);
        check("t7_second", 64'(dv), 64'b010);
        check("t7_gap2", 64'(gap_at_rise), 64'd3);
        run_txn(40, 3'b111, dv);
        check("t7_third", 64'(dv), 64'b100);
        check("t7_gap3", 64'(gap_at_rise), 64'd3);
        run_txn(40, 3'b111, dv);
        check("t7_fourth", 64'(dv), 64'b001);
        check("t7_gap4", 64'(gap_at_rise), 64'd3);
        req_valid = 3'b000;
        tick();
        tick();
        check("t7_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riffa_tx_arbiter.md
Name: riffa_tx_arbiter

Overview:
- Shares one RIFFA TX channel among NUM_REQ internal requesters, e.g. register-read responses, DDR readback and status/interrupt messages.
- Grants requesters round-robin and runs the CHNL_TX / CHNL_TX_ACK handshake for the granted one.
- Muxes the granted requester's data onto the channel and counts words to close each transaction.
- Sits between the command-execution pipeline and the RIFFA channel TX port.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 64, channel data width in bits (multiple of 32).
- LEN_W, 32, width of length fields (units of 32-bit words).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a transaction pending.
- req_len  in  NUM_REQ*LEN_W  per-requester length in 32-bit words.
- req_last  in  NUM_REQ  per-requester value for CHNL_TX_LAST.
- req_grant  out  NUM_REQ  one-hot; asserted for the whole owned transaction.
- req_data  in  NUM_REQ*DATA_W  per-requester data.
- req_data_valid  in  NUM_REQ  per-requester data valid.
- req_data_ren  out  NUM_REQ  data accepted (grant & CHNL_TX_DATA_REN).
- req_done  out  NUM_REQ  1-cycle pulse when requester i's transaction completes.
- CHNL_TX  out  1  RIFFA TX transaction request.
- CHNL_TX_ACK  in  1  RIFFA acknowledge.
- CHNL_TX_LAST  out  1  latched req_last of the owner.
- CHNL_TX_LEN  out  LEN_W  latched req_len of the owner.
- CHNL_TX_OFF  out  31  constant 0.
- CHNL_TX_DATA  out  DATA_W  owner's req_data (combinational mux).
- CHNL_TX_DATA_VALID  out  1  owner's req_data_valid, gated to XFER.
- CHNL_TX_DATA_REN  in  1  RIFFA read enable.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; word counter 0.
- Reset asserted mid-transaction: everything abandons immediately; no req_done pulse.
- IDLE:
  - Any req_valid -> ARB next cycle.
- ARB (1 cycle):
  - Round-robin select: first req_valid at or after pointer+1 (mod NUM_REQ); after reset, index 0 has highest priority.
  - Register the owner index, req_len, req_last and one-hot req_grant.
  - If req_valid has dropped to all 0 -> IDLE with no grant.
  - Otherwise -> REQ.
- Requester rules:
  - A requester may withdraw req_valid before it is granted.
  - Once granted, req_len, req_last and req_valid are ignored until req_done.
- REQ:
  - CHNL_TX=1; CHNL_TX_LEN and CHNL_TX_LAST driven from the latched values.
  - Wait unbounded for CHNL_TX_ACK.
  - On ACK: if latched len==0 -> DONE, else -> XFER.
- XFER:
  - CHNL_TX stays 1.
  - Word beat = CHNL_TX_DATA_VALID & CHNL_TX_DATA_REN.
  - Counter += DATA_W/32 per beat (LEN_W+1 bits, no wrap).
  - When counter >= latched len (after a beat, so odd len ends on a padded final beat) -> DONE.
  - CHNL_TX drops in the same cycle that state leaves XFER.
- DONE (1 cycle):
  - CHNL_TX=0, pulse req_done[owner], clear the grant, pointer := owner, counter := 0 -> IDLE.
  - Minimum gap between consecutive CHNL_TX transactions: 2 cycles (DONE, IDLE), plus ARB.
- req_data_ren and CHNL_TX_DATA_VALID are 0 outside XFER and for non-owners.
- Simultaneous requests: strict round-robin, so no requester waits more than NUM_REQ-1 transactions.
- A requester whose req_valid is still high after DONE re-enters arbitration with lowest priority.

Decomposition:
- Shared package riffa_pkg:
  - state encoding localparams IDLE/ARB/REQ/XFER/DONE;
  - WORDS_PER_BEAT = DATA_W/32;
  - default width constants.
- One sub-module: rr_arbiter (NUM_REQ). Combinational request vector plus pointer in; one-hot grant plus index out.

Test Plan:
- Single requester 1, len=4, DATA_W=64, REN always 1 -> CHNL_TX high from REQ; 2 beats accepted; CHNL_TX low after 2nd beat; req_done[1] pulses once; CHNL_TX_LEN=4.
- All 3 request simultaneously after reset, len=2 each -> grant order 0,1,2; then 0 again if it re-requests; CHNL_TX low ≥2 cycles between transactions.
- len=3 (odd), 64-bit -> 2 beats transferred, then DONE; counter reads 4 at end.
- len=0 -> CHNL_TX asserted until ACK; zero data beats; req_done in the cycle after ACK.
- REN toggling 1/0/1/0 with valid high, len=8 -> exactly 4 beats counted; req_data_ren mirrors REN only for the owner.
- rst_n pulsed low mid-XFER -> all outputs 0 asynchronously; no req_done; next request arbitrated with pointer 0.
